// File: rtl/field_pack_pkg.sv
// Shared constants, state encoding and field masking for the MSB-first field packer.
package field_pack_pkg;

  localparam int unsigned OUT_W       = 8;
  localparam int unsigned MAX_FIELD_W = 8;
  localparam int unsigned LEN_W       = 4;
  localparam int unsigned ACC_W       = 16;
  localparam int unsigned CNT_W       = $clog2(ACC_W) + 1;
  localparam int unsigned MASK_W      = MAX_FIELD_W + 1;

  typedef enum logic {
    PACK  = 1'b0,
    FLUSH = 1'b1
  } pack_st_t;

  // Keep only the low 'len' bits of a right-aligned field.
  function automatic logic [MAX_FIELD_W-1:0] field_mask(
    input logic [MAX_FIELD_W-1:0] data,
    input logic [LEN_W-1:0]       len
  );
    logic [MASK_W-1:0] m;
    m = (MASK_W'(1) << len) - MASK_W'(1);
    return data & m[MAX_FIELD_W-1:0];
  endfunction

endpackage

// File: rtl/field_pack_ctrl_if.sv
// Field-in / byte-out handshake bundle for the field packer.
interface field_pack_ctrl_if;
  import field_pack_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [MAX_FIELD_W-1:0] in_data;
  logic [LEN_W-1:0]       in_len;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [OUT_W-1:0]       out_data;
  logic                   out_last;
  logic [LEN_W-1:0]       out_pad;
  logic                   err_len;

  modport slave (
    input  in_valid, in_data, in_len, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_pad, err_len
  );

  modport master (
    output in_valid, in_data, in_len, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_pad, err_len
  );
endinterface

// File: rtl/field_pack_align.sv
// Masks an incoming field to its length and places it just below the bits already held.
module field_pack_align
  import field_pack_pkg::*;
(
  input  logic [MAX_FIELD_W-1:0] in_data,
  input  logic [LEN_W-1:0]       in_len,
  input  logic [CNT_W-1:0]       cnt,
  output logic [ACC_W-1:0]       aligned_c
);

  logic [CNT_W-1:0] shamt;

  // cnt < OUT_W and len <= MAX_FIELD_W whenever this result is used, so shamt never wraps.
  always_comb begin
    shamt     = CNT_W'(ACC_W) - cnt - CNT_W'(in_len);
    aligned_c = ACC_W'(field_mask(in_data, in_len)) << shamt;
  end

endmodule

// File: rtl/field_pack_ctrl.sv
// Packs 1..8-bit fields MSB-first into bytes, zero-padding the last byte of each packet.
module field_pack_ctrl
  import field_pack_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  field_pack_ctrl_if.slave  bus
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  pack_st_t         st_q,  st_d;
  logic             err_len_q, err_len_d;

  logic [ACC_W-1:0] aligned_c;
  logic             in_ready_c;
  logic             out_valid_c;
  logic             out_last_c;
  logic             len_ok_c;

  field_pack_align u_align (
    .in_data   (bus.in_data),
    .in_len    (bus.in_len),
    .cnt       (cnt_q),
    .aligned_c (aligned_c)
  );

  // Handshake and byte view, derived from state only.
  always_comb begin
    in_ready_c  = (st_q == PACK) && (cnt_q < CNT_W'(OUT_W));
    out_valid_c = (cnt_q >= CNT_W'(OUT_W)) || ((st_q == FLUSH) && (cnt_q != '0));
    out_last_c  = (st_q == FLUSH) && (cnt_q <= CNT_W'(OUT_W));
    len_ok_c    = (bus.in_len != '0) && (bus.in_len <= LEN_W'(MAX_FIELD_W));
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = acc_q[ACC_W-1 -: OUT_W];
  assign bus.out_last  = out_last_c;
  assign bus.out_pad   = out_last_c ? LEN_W'(CNT_W'(OUT_W) - cnt_q) : '0;
  assign bus.err_len   = err_len_q;

  // Accept and pop never coincide: accept needs cnt < OUT_W in PACK, a PACK pop needs cnt >= OUT_W.
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    st_d      = st_q;
    err_len_d = 1'b0;
    if (bus.in_valid && in_ready_c) begin
      if (len_ok_c) begin
        acc_d = acc_q | aligned_c;
        cnt_d = cnt_q + CNT_W'(bus.in_len);
        if (bus.in_last) st_d = FLUSH;
      end else begin
        err_len_d = 1'b1;
      end
    end else if (out_valid_c && bus.out_ready) begin
      acc_d = acc_q << OUT_W;
      cnt_d = (cnt_q > CNT_W'(OUT_W)) ? cnt_q - CNT_W'(OUT_W) : '0;
      if (out_last_c) st_d = PACK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      st_q      <= PACK;
      err_len_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      st_q      <= st_d;
      err_len_q <= err_len_d;
    end
  end

endmodule

// File: tb/tb_field_pack_ctrl.sv
// Directed bench for field_pack_ctrl: packing, flush/pad, backpressure, illegal lengths, reset.
module tb_field_pack_ctrl;
  import field_pack_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  field_pack_ctrl_if bus();

  field_pack_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int err_cycles = 0;
  logic [12:0] got_q[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Record each popped byte as {last, pad, data}.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready)
        got_q.push_back({bus.out_last, bus.out_pad, bus.out_data});
      if (bus.err_len) err_cycles++;
    end
  end

  task automatic send(input logic [3:0] len, input logic [7:0] data, input logic last);
    int n;
    bus.in_valid = 1'b1;
    bus.in_len   = len;
    bus.in_data  = data;
    bus.in_last  = last;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("send_timeout", 32'(n >= 50), 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while ((bus.out_valid || !bus.in_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_idle_timeout"}, 32'(n >= 100), 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic expect_byte(input string tag, input int idx,
                             input logic [7:0] data, input logic last, input logic [3:0] pad);
    logic [12:0] g;
    g = (idx < got_q.size()) ? got_q[idx] : 13'h1fff;
    check_eq({tag, "_data"}, 32'(g[7:0]),  32'(data));
    check_eq({tag, "_last"}, 32'(g[12]),   32'(last));
    check_eq({tag, "_pad"},  32'(g[11:8]), 32'(pad));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    check_eq({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check_eq({tag, "_out_data"},  32'(bus.out_data),  32'd0);
    check_eq({tag, "_out_last"},  32'(bus.out_last),  32'd0);
    check_eq({tag, "_out_pad"},   32'(bus.out_pad),   32'd0);
    check_eq({tag, "_err_len"},   32'(bus.err_len),   32'd0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_len    = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fields 01, 011, 1011 -> 0101_1101, 1000_0000 (pad 7).
    got_q.delete();
    send(4'd2, 8'b01, 1'b0);
    send(4'd3, 8'b011, 1'b0);
    send(4'd4, 8'b1011, 1'b1);
    wait_idle("s1");
    check_eq("s1_count", 32'(got_q.size()), 32'd2);
    expect_byte("s1_b0", 0, 8'h5D, 1'b0, 4'd0);
    expect_byte("s1_b1", 1, 8'h80, 1'b1, 4'd7);

    // Two full bytes; controller stalls input right after each full-byte accept.
    got_q.delete();
    send(4'd8, 8'hA5, 1'b0);
    check_eq("s2_ready_after_a5", 32'(bus.in_ready), 32'd0);
    send(4'd8, 8'h3C, 1'b1);
    check_eq("s2_ready_after_3c", 32'(bus.in_ready), 32'd0);
    wait_idle("s2");
    check_eq("s2_count", 32'(got_q.size()), 32'd2);
    expect_byte("s2_b0", 0, 8'hA5, 1'b0, 4'd0);
    expect_byte("s2_b1", 1, 8'h3C, 1'b1, 4'd0);

    // Backpressure holds the first byte stable.
    got_q.delete();
    bus.out_ready = 1'b0;
    send(4'd2, 8'b01, 1'b0);
    send(4'd3, 8'b011, 1'b0);
    send(4'd4, 8'b1011, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("s3_hold_valid", 32'(bus.out_valid), 32'd1);
      check_eq("s3_hold_data",  32'(bus.out_data),  32'h5D);
      check_eq("s3_hold_last",  32'(bus.out_last),  32'd0);
      check_eq("s3_hold_ready", 32'(bus.in_ready),  32'd0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_idle("s3");
    check_eq("s3_count", 32'(got_q.size()), 32'd2);
    expect_byte("s3_b0", 0, 8'h5D, 1'b0, 4'd0);
    expect_byte("s3_b1", 1, 8'h80, 1'b1, 4'd7);

    // Illegal lengths are dropped (including in_last) and flagged.
    got_q.delete();
    err_cycles = 0;
    send(4'd0, 8'h55, 1'b0);
    send(4'd9, 8'hFF, 1'b1);
    send(4'd8, 8'hFF, 1'b1);
    wait_idle("s4");
    check_eq("s4_err_pulses", 32'(err_cycles), 32'd2);
    check_eq("s4_count", 32'(got_q.size()), 32'd1);
    expect_byte("s4_b0", 0, 8'hFF, 1'b1, 4'd0);

    // Upper bits beyond in_len are masked off.
    got_q.delete();
    send(4'd3, 8'hFF, 1'b1);
    wait_idle("s5");
    check_eq("s5_count", 32'(got_q.size()), 32'd1);
    expect_byte("s5_b0", 0, 8'hE0, 1'b1, 4'd5);

    // Reset mid-packet discards the partial field.
    got_q.delete();
    send(4'd4, 8'b1010, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("s6_rst");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("s6_rst_hold");
    rst_n = 1'b1;
    @(posedge clk); #1;
    got_q.delete();
    send(4'd8, 8'h12, 1'b1);
    wait_idle("s6");
    check_eq("s6_count", 32'(got_q.size()), 32'd1);
    expect_byte("s6_b0", 0, 8'h12, 1'b1, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/field_pack_ctrl.md
Name: field_pack_ctrl

Overview:
Sequencing controller for the bit-concatenation datapath. It accepts a stream of variable-width fields (1..8 bits each) over a valid/ready handshake and packs them MSB-first, in arrival order, into a stream of 8-bit output bytes. The first field lands in the most significant bits, matching `{a,b,c}` ordering. It sits between field producers (header/flag builders) and a byte-wide sink, and zero-pads the final byte of a packet on `in_last`.

Parameters:
- OUT_W, 8, output byte width; the design is verified only at 8.
- MAX_FIELD_W, 8, maximum legal field width; must be <= OUT_W.
- LEN_W, 4, width of `in_len`.
- ACC_W, 16, accumulator width; must be >= OUT_W + MAX_FIELD_W.

Ports:
- clk  in  1  single clock; all state on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  field beat valid.
- in_ready  out  1  controller can accept a field.
- in_data  in  MAX_FIELD_W  field value, right-aligned; bits at or above `in_len` are ignored.
- in_len  in  LEN_W  field width in bits; legal range 1..MAX_FIELD_W.
- in_last  in  1  last field of the packet; triggers flush.
- out_valid  out  1  byte available.
- out_ready  in  1  sink accepts the byte.
- out_data  out  OUT_W  packed byte; the earliest bit is the MSB.
- out_last  out  1  final byte of the packet.
- out_pad  out  LEN_W  count of zero pad bits in the LSBs of `out_data`; nonzero only with `out_last`.
- err_len  out  1  one-cycle pulse on an illegal-length beat.

Behaviour:
- State:
  - `acc[ACC_W-1:0]` holds valid bits left-aligned: `acc[ACC_W-1 : ACC_W-cnt]`.
  - `cnt` ranges 0..ACC_W-1.
  - `st` is one of PACK or FLUSH.
- Reset (async, rst_n=0):
  - acc=0, cnt=0, st=PACK, err_len=0.
  - Derived outputs: in_ready=1, out_valid=0, out_data=0, out_last=0, out_pad=0.
  - Reset mid-packet discards partial bits; nothing is emitted.
- Output definitions (combinational from registers only; no input-to-output paths):
  - `in_ready = (st==PACK) && (cnt < OUT_W)`.
  - `out_valid = (cnt >= OUT_W) || (st==FLUSH && cnt > 0)`.
  - `out_data = acc[ACC_W-1 : ACC_W-OUT_W]`. Bits below `cnt` are always 0 because acc is kept clean, so padding is implicit.
  - `out_last = (st==FLUSH) && (cnt <= OUT_W)`.
  - `out_pad = out_last ? OUT_W - cnt : 0`.
- Accept (`in_valid && in_ready`, legal `in_len`):
  - `acc <= acc | (mask(in_data,in_len) << (ACC_W - cnt - in_len))`.
  - `cnt <= cnt + in_len`.
  - If `in_last`, then `st <= FLUSH`.
- Illegal length (`in_len==0` or `in_len>MAX_FIELD_W`) while `in_valid && in_ready`:
  - The beat is consumed and dropped, including its `in_last`.
  - acc, cnt and st are unchanged.
  - `err_len=1` for the next cycle only.
- Pop (`out_valid && out_ready`):
  - `acc <= acc << OUT_W` with zero fill.
  - `cnt <= (cnt > OUT_W) ? cnt - OUT_W : 0`.
  - If `out_last`, then `st <= PACK`.
- Accept and pop are mutually exclusive by construction: `in_ready` requires cnt<8 in PACK, and a PACK pop requires cnt>=8.
- Throughput: one byte every 2 cycles worst case (len=8 stream). This is accepted.
- Latency: a byte completed by an accept is presented `out_valid` on the following cycle.
- FLUSH:
  - `in_ready=0`.
  - Drains full bytes, then the padded final byte with `out_last`.
  - If `cnt` is an exact multiple of 8, the last full byte carries `out_last` with `out_pad=0`.
- Backpressure: while `out_valid && !out_ready`, out_data, out_last and out_pad are held stable.
- `cnt>0` always holds after a legal accept, so `in_last` always yields exactly one `out_last` byte.

Decomposition:
- Package `field_pack_pkg`:
  - Constants OUT_W, MAX_FIELD_W, LEN_W, ACC_W.
  - State enum `pack_st_t {PACK, FLUSH}`.
  - Function `field_mask(data,len)`.
- Sub-module `field_pack_align` (combinational): masks `in_data` to `in_len` and shifts it to position `ACC_W-cnt-len`. It is kept separate so it can be unit-tested independently.

Test Plan:
- Fields {len2 `01`}, {len3 `011`}, {len4 `1011`, last}, with out_ready=1 -> bytes 0x5D (`out_last=0`), then 0x80 (`out_last=1`, `out_pad=7`).
- Fields {len8 0xA5}, {len8 0x3C, last} -> in_ready=0 the cycle after each accept; bytes 0xA5, then 0x3C (`out_last=1`, `out_pad=0`).
- Same stimulus as the first scenario, with out_ready=0 for 5 cycles after the first out_valid -> out_data=0x5D held stable, in_ready=0, then the sequence completes unchanged.
- Beats with len=0 and len=9 (one with in_last=1), then legal {len8 0xFF, last} -> err_len pulses once per illegal beat, no output from them; then a single byte 0xFF with `out_last=1`.
- {len3 in_data=0xFF, last} -> byte 0xE0 (upper bits masked), `out_pad=5`.
- {len4 `1010`}, then rst_n=0 for 2 cycles mid-packet, then {len8 0x12, last} -> after reset all outputs are 0 and in_ready=1; the only byte emitted is 0x12 with `out_last=1`.
